// File: rtl/slow_clock_monitor.sv
// Synchronizes a slow square wave, strobes its edges and measures the half-period; reports lock/stall.
// Latency: edge strobes and captures appear SYNC_STAGES+1 cycles after sampling; no backpressure (free-running observer).
module slow_clock_monitor #(
    parameter int COUNT_WIDTH    = 23,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 8000000,
    parameter int LOCK_TOLERANCE = 1,
    parameter int LOCK_COUNT     = 4
) (
    input  logic                   clock_in,
    input  logic                   reset_n,
    input  logic                   signal_in,
    output logic                   level,
    output logic                   rise_pulse,
    output logic                   fall_pulse,
    output logic [COUNT_WIDTH-1:0] half_period,
    output logic                   period_valid,
    output logic                   locked,
    output logic                   stalled
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0]          LOCK_CNT_V = MW'(LOCK_COUNT);
    localparam logic [COUNT_WIDTH:0]   TOL_V      = (COUNT_WIDTH + 1)'(LOCK_TOLERANCE);
    localparam logic [COUNT_WIDTH-1:0] TMO_V      = COUNT_WIDTH'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [MW-1:0]          r_match;
    logic [1:0]             r_state;
    logic                   r_first;

    logic                   w_rise;
    logic                   w_fall;
    logic                   w_edge;
    logic [COUNT_WIDTH:0]   w_meas;
    logic [COUNT_WIDTH:0]   w_prev;
    logic [COUNT_WIDTH:0]   w_diff;
    logic [COUNT_WIDTH-1:0] w_meas_sat;
    logic                   w_match;
    logic [MW-1:0]          w_match_nxt;
    logic                   w_timeout;

    assign level  = r_sync[SYNC_STAGES-1];
    assign w_rise = level & ~r_dly;
    assign w_fall = ~level & r_dly;
    assign w_edge = w_rise | w_fall;

    // Counter+1 is the number of cycles since the previous edge; widened so it cannot wrap.
    assign w_meas      = {1'b0, r_count} + {{COUNT_WIDTH{1'b0}}, 1'b1};
    assign w_prev      = {1'b0, half_period};
    assign w_diff      = (w_meas >= w_prev) ? (w_meas - w_prev) : (w_prev - w_meas);
    assign w_meas_sat  = w_meas[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}} : w_meas[COUNT_WIDTH-1:0];
    assign w_match     = ~r_first && (w_diff <= TOL_V);
    assign w_match_nxt = (r_match >= LOCK_CNT_V) ? r_match : r_match + MW'(1);
    assign w_timeout   = ~w_edge && (r_count == TMO_V);

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sync     <= '0;
            r_dly      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], signal_in};
            r_dly      <= level;
            rise_pulse <= w_rise;
            fall_pulse <= w_fall;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_edge) begin
            r_count <= '0;
        end else if (r_count != {COUNT_WIDTH{1'b1}}) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_SEARCH;
            r_match      <= '0;
            r_first      <= 1'b0;
            half_period  <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (r_state)
                ST_SEARCH: begin
                    if (w_edge) begin
                        stalled <= 1'b0;
                        r_first <= 1'b1;
                        r_match <= '0;
                        r_state <= ST_MEASURE;
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    if (w_edge) begin
                        half_period  <= w_meas_sat;
                        period_valid <= 1'b1;
                        r_first      <= 1'b0;
                        if (w_match) begin
                            r_match <= w_match_nxt;
                            if (r_state == ST_MEASURE && w_match_nxt >= LOCK_CNT_V) begin
                                locked  <= 1'b1;
                                r_state <= ST_LOCKED;
                            end
                        end else begin
                            r_match <= '0;
                            locked  <= 1'b0;
                            r_state <= ST_MEASURE;
                        end
                    end else if (w_timeout) begin
                        stalled <= 1'b1;
                        locked  <= 1'b0;
                        r_match <= '0;
                        r_state <= ST_SEARCH;
                    end
                end
                default: r_state <= ST_SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Directed bench for slow_clock_monitor: edge strobes, half-period capture, lock, stall and reset.
module tb_slow_clock_monitor;

    localparam int CW = 8;

    logic          clock_in = 1'b0;
    logic          reset_n  = 1'b0;
    logic          signal_in = 1'b0;
    logic          level, rise_pulse, fall_pulse, period_valid, locked, stalled;
    logic [CW-1:0] half_period;

    slow_clock_monitor #(
        .COUNT_WIDTH    (CW),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (50),
        .LOCK_TOLERANCE (1),
        .LOCK_COUNT     (4)
    ) dut (
        .clock_in     (clock_in),
        .reset_n      (reset_n),
        .signal_in    (signal_in),
        .level        (level),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .half_period  (half_period),
        .period_valid (period_valid),
        .locked       (locked),
        .stalled      (stalled)
    );

    always #5 clock_in = ~clock_in;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int cap_hp[$];
    int cap_lk[$];
    int exp_hp[$];
    int exp_lk[$];
    int rise_cnt, fall_cnt, alt_err, last_type;
    int last_pulse_cyc, stall_cyc;
    bit stall_seen;

    always @(posedge clock_in) cyc <= cyc + 1;

    always @(negedge clock_in) begin
        if (!reset_n) begin
            last_type = 0;
        end else begin
            if (period_valid) begin
                cap_hp.push_back(int'(half_period));
                cap_lk.push_back(int'(locked));
            end
            if (rise_pulse) begin
                rise_cnt++;
                if (last_type == 1) alt_err++;
                last_type = 1;
                last_pulse_cyc = cyc;
            end
            if (fall_pulse) begin
                fall_cnt++;
                if (last_type == 2) alt_err++;
                last_type = 2;
                last_pulse_cyc = cyc;
            end
            if (stalled && !stall_seen) begin
                stall_seen = 1'b1;
                stall_cyc  = cyc;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    task automatic clear_stats();
        cap_hp.delete();
        cap_lk.delete();
        exp_hp.delete();
        exp_lk.delete();
        rise_cnt   = 0;
        fall_cnt   = 0;
        alt_err    = 0;
        stall_seen = 1'b0;
    endtask

    task automatic do_reset(input logic sig);
        reset_n   = 1'b0;
        signal_in = sig;
        tick(3);
        clear_stats();
        reset_n = 1'b1;
    endtask

    task automatic square(input int n, input int k);
        repeat (k) begin
            signal_in = ~signal_in;
            tick(n);
        end
    endtask

    task automatic jitter(input int a, input int b, input int pairs);
        repeat (pairs) begin
            signal_in = ~signal_in;
            tick(a);
            signal_in = ~signal_in;
            tick(b);
        end
    endtask

    task automatic expect_cap(input int hp, input int lk);
        exp_hp.push_back(hp);
        exp_lk.push_back(lk);
    endtask

    task automatic verify_caps(input string tag);
        check_eq({tag, "_ncap"}, cap_hp.size(), exp_hp.size());
        for (int i = 0; i < exp_hp.size() && i < cap_hp.size(); i++) begin
            check_eq($sformatf("%s_hp%0d", tag, i), cap_hp[i], exp_hp[i]);
            check_eq($sformatf("%s_lk%0d", tag, i), cap_lk[i], exp_lk[i]);
        end
        cap_hp.delete();
        cap_lk.delete();
        exp_hp.delete();
        exp_lk.delete();
    endtask

    initial begin
        // Reset with signal high: outputs cleared, then a single rise after release.
        reset_n   = 1'b0;
        signal_in = 1'b1;
        tick(3);
        check_eq("rst_level", level, 0);
        check_eq("rst_rise", rise_pulse, 0);
        check_eq("rst_hp", half_period, 0);
        check_eq("rst_pv", period_valid, 0);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_stalled", stalled, 0);
        clear_stats();
        reset_n = 1'b1;
        tick(2);
        check_eq("rel_rise_early", rise_pulse, 0);
        tick(1);
        check_eq("rel_level", level, 1);
        check_eq("rel_rise", rise_pulse, 1);
        tick(4);
        check_eq("rel_rise_cnt", rise_cnt, 1);
        check_eq("rel_pv_cnt", cap_hp.size(), 0);
        check_eq("rel_locked", locked, 0);
        check_eq("rel_stalled", stalled, 0);

        // Square wave of 5: lock on the fifth capture.
        do_reset(1'b0);
        tick(10);
        square(5, 8);
        for (int i = 0; i < 7; i++) expect_cap(5, (i >= 4) ? 1 : 0);
        verify_caps("sq5");

        // Switch to 9: first 5-interval still matches, first 9 unlocks, relock after four more.
        square(9, 6);
        expect_cap(5, 1);
        for (int i = 0; i < 5; i++) expect_cap(9, (i == 4) ? 1 : 0);
        verify_caps("sq9");
        check_eq("alt_rise_cnt", rise_cnt, 7);
        check_eq("alt_fall_cnt", fall_cnt, 7);
        check_eq("alt_err", alt_err, 0);

        // Jitter 5/6 within tolerance locks.
        do_reset(1'b0);
        tick(5);
        jitter(5, 6, 4);
        for (int i = 0; i < 7; i++) expect_cap((i % 2 == 0) ? 5 : 6, (i >= 4) ? 1 : 0);
        verify_caps("jit56");

        // Jitter 5/7 never locks.
        do_reset(1'b0);
        tick(5);
        jitter(5, 7, 4);
        for (int i = 0; i < 7; i++) expect_cap((i % 2 == 0) ? 5 : 7, 0);
        verify_caps("jit57");

        // Stall: frozen input after lock.
        do_reset(1'b0);
        tick(5);
        square(5, 8);
        check_eq("tmo_pre_locked", locked, 1);
        cap_hp.delete();
        cap_lk.delete();
        tick(70);
        check_eq("tmo_seen", stall_seen, 1);
        check_eq("tmo_delay", stall_cyc - last_pulse_cyc, 51);
        check_eq("tmo_stalled", stalled, 1);
        check_eq("tmo_locked", locked, 0);
        check_eq("tmo_hp_kept", half_period, 5);
        signal_in = ~signal_in;
        tick(6);
        check_eq("tmo_clear", stalled, 0);
        check_eq("tmo_nocap", cap_hp.size(), 0);
        signal_in = ~signal_in;
        tick(6);
        expect_cap(6, 0);
        verify_caps("tmo_after");

        // Asynchronous reset while locked.
        do_reset(1'b0);
        tick(5);
        square(5, 8);
        check_eq("ar_pre_locked", locked, 1);
        @(posedge clock_in);
        #1;
        reset_n = 1'b0;
        #2;
        check_eq("ar_locked", locked, 0);
        check_eq("ar_hp", half_period, 0);
        check_eq("ar_pv", period_valid, 0);
        check_eq("ar_stalled", stalled, 0);
        signal_in = 1'b0;
        tick(2);
        clear_stats();
        reset_n = 1'b1;
        tick(4);
        signal_in = 1'b1;
        tick(6);
        check_eq("ar_first_nocap", cap_hp.size(), 0);
        check_eq("ar_first_rise", rise_cnt, 1);
        signal_in = 1'b0;
        tick(6);
        expect_cap(6, 0);
        verify_caps("ar_second");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/slow_clock_monitor.md
Name: slow_clock_monitor

Overview:
- Consumes a slow square wave (e.g. a divided clock_out, or an external slow clock) as a data input in the fast clock_in domain.
- Synchronizes the input, emits single-cycle rise/fall pulses, and measures the half-period in clock_in cycles.
- Reports lock when the measured half-period is stable, and flags a stall when edges stop arriving.
- Sits beside each divider instance as its checker, and in front of any logic that needs edge strobes from a slow clock.

Parameters:
- COUNT_WIDTH, 23, width of the interval counter and of half_period.
- SYNC_STAGES, 2, number of synchronizer flops on signal_in; legal values are 2 or more.
- TIMEOUT_CYCLES, 8000000, cycles without any detected edge before a stall is declared; must be less than 2^COUNT_WIDTH-1.
- LOCK_TOLERANCE, 1, maximum absolute difference between consecutive measurements still counted as a match.
- LOCK_COUNT, 4, number of consecutive matching measurements required to assert locked.

Ports:
- clock_in, input, 1, fast system clock; all logic on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- signal_in, input, 1, slow asynchronous square wave.
- level, output, 1, synchronized copy of signal_in.
- rise_pulse, output, 1, one-cycle strobe per detected rising edge.
- fall_pulse, output, 1, one-cycle strobe per detected falling edge.
- half_period, output, COUNT_WIDTH, last measured edge-to-edge interval in clock_in cycles.
- period_valid, output, 1, one-cycle strobe when half_period updates.
- locked, output, 1, measurement stable.
- stalled, output, 1, no edge seen for TIMEOUT_CYCLES cycles.

Behaviour:
- Reset (asynchronous, reset_n low):
  - all synchronizer flops, the delayed level and every output go to 0;
  - the interval counter and match count go to 0;
  - state goes to SEARCH.
  - Reset mid-measurement discards everything; the first edge after release is treated as in SEARCH.
- Synchronizer and edge detection:
  - The SYNC_STAGES chain feeds level; a delayed copy of level is registered one cycle later.
  - rise = level & ~delayed, fall = ~level & delayed.
  - rise_pulse and fall_pulse are registered versions of rise and fall.
  - Latency: signal_in first sampled high at clock_in edge k gives rise_pulse high from edge k+SYNC_STAGES to edge k+SYNC_STAGES+1. Falling edges behave the same way.
  - A pulse on signal_in shorter than one clock_in period may be missed; this is allowed.
- Interval counter:
  - Cleared to 0 in any cycle where rise or fall is detected.
  - Otherwise increments, saturating at all-ones.
  - The measurement captured on an edge is counter+1, which equals the number of clock_in cycles since the previous edge.
  - A divider toggling every N cycles therefore measures N.
- State machine (SEARCH, MEASURE, LOCKED):
  - SEARCH:
    - First detected edge: clear the counter, clear stalled, go to MEASURE.
    - No capture and no period_valid on this edge.
  - MEASURE, on each edge:
    - Load half_period and pulse period_valid, registered together in the cycle after the edge is detected (aligned with rise_pulse/fall_pulse).
    - If |new − previous half_period| ≤ LOCK_TOLERANCE, increment the match count; otherwise set it to 0.
    - The first capture after SEARCH never matches; the match count is set to 0.
    - When the match count reaches LOCK_COUNT, set locked=1 and go to LOCKED.
  - LOCKED, on each edge:
    - Capture as in MEASURE.
    - A mismatch sets locked=0, sets the match count to 0, and returns to MEASURE.
  - Timeout, in MEASURE or LOCKED:
    - Triggered when the counter equals TIMEOUT_CYCLES and no edge is detected that cycle.
    - Sets stalled=1, locked=0 and the match count to 0, and goes to SEARCH.
    - half_period holds its last value.
  - SEARCH never times out. stalled stays 1 until the next detected edge.
- Simultaneous events:
  - An edge detected in the same cycle the counter reaches TIMEOUT_CYCLES is an edge; there is no timeout.
  - rise and fall are never both set.
- Arithmetic: the difference is computed in COUNT_WIDTH+1 bits, unsigned magnitude, with no wrap.

Test Plan:
- Reset with signal_in held high, then release:
  - after SYNC_STAGES+1 cycles, level=1 with exactly one rise_pulse;
  - no period_valid, locked=0, stalled=0.
- Drive signal_in as a square wave toggling every 5 cycles (a divider with half_divide_by=5):
  - every edge after the first gives period_valid with half_period=5;
  - locked rises on the 5th capture (1 non-matching + 4 matches);
  - rise_pulse and fall_pulse alternate.
- Locked at 5, then switch to toggling every 9 cycles:
  - the first capture of 9 drops locked and returns to MEASURE;
  - locked re-asserts after 4 further captures of 9.
- Jitter of 5/6 alternating with LOCK_TOLERANCE=1 → lock is achieved.
- Jitter of 5/7 alternating → locked never asserts.
- TIMEOUT_CYCLES=50, signal_in frozen after lock:
  - stalled=1 and locked=0 exactly 50 counter cycles after the last edge;
  - half_period is retained;
  - the next edge clears stalled and produces no capture.
- Assert reset_n mid-stream while locked:
  - all outputs return to 0 immediately (asynchronously);
  - after release, the first edge is not captured.
